// File: rtl/frame_check_pkg.sv
// Shared constants for the multi-channel AXI-Stream frame checker: reason codes,
// FSM encoding, and the LFSR used when FRAME_CHECK_THROTTLE_EN is defined.
// No logic here; latency and backpressure are defined by the modules that import it.
package frame_check_pkg;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_KEEP    = 3'd1;
  localparam logic [2:0] ERR_PATTERN = 3'd2;
  localparam logic [2:0] ERR_PORT    = 3'd3;
  localparam logic [2:0] ERR_LEN     = 3'd4;
  localparam logic [2:0] ERR_SEQ     = 3'd5;
  localparam logic [2:0] ERR_BADCH   = 3'd6;

  localparam logic [0:0] S_FIRST = 1'b0;
  localparam logic [0:0] S_BODY  = 1'b1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over state bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/frame_check_mc_lfsr16.sv
// 16-bit Fibonacci LFSR that drives the pseudo-random tready throttle.
// Latency: state advances one step per enabled clock. Backpressure: none, free-running.
// Only instantiated in FRAME_CHECK_THROTTLE_EN builds.
module lfsr16
  import frame_check_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/frame_check_mc.sv
// Multi-channel AXI-Stream sink checker: pattern, tkeep, length, port and sequence checks.
// Latency: the frame result (err_*, counters) lands one cycle after the tlast beat.
// Backpressure: tready is 1 after reset, or LFSR-throttled under FRAME_CHECK_THROTTLE_EN.
module frame_check_mc
  import frame_check_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_CH     = 8,
  parameter int PORT_WIDTH = 3,
  parameter int LEN_WIDTH  = 14,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    axi_resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [LEN_WIDTH-1:0]    s_axis_tuser_packet_length,
  input  logic [PORT_WIDTH-1:0]   s_axis_tuser_in_port,
  input  logic [7:0]              s_axis_tuser_out_port,
  input  logic [PORT_WIDTH-1:0]   s_axis_tuser_in_vport,
  input  logic [7:0]              s_axis_tuser_out_vport,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    stat_clear,
  input  logic [PORT_WIDTH-1:0]   stat_ch_sel,
  output logic [CNT_WIDTH-1:0]    stat_good,
  output logic [CNT_WIDTH-1:0]    stat_bad,
  output logic                    err_valid,
  output logic [2:0]              err_code,
  output logic [PORT_WIDTH-1:0]   err_ch
);

  localparam int KW  = DATA_WIDTH / 8;
  localparam int KCW = $clog2(KW + 1);
  localparam int CW  = LEN_WIDTH + 1;
  localparam int CW1 = CW + 1;
  localparam int PW1 = PORT_WIDTH + 1;

  logic                  unused_ok;
  assign unused_ok = ^{s_axis_tuser_out_port, s_axis_tuser_in_vport, s_axis_tuser_out_vport};

  logic [0:0]            state;
  logic [PORT_WIDTH-1:0] ch_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [7:0]            base_q;
  logic [7:0]            off_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            code_q;

  logic [CNT_WIDTH-1:0]  good [NUM_CH];
  logic [CNT_WIDTH-1:0]  bad  [NUM_CH];
  logic [7:0]            exp_base [NUM_CH];
  logic [NUM_CH-1:0]     seed_valid;

  logic                  xfer, first, frame_end;
  logic [PORT_WIDTH-1:0] cur_ch;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [7:0]            cur_base, cur_off;
  logic [CW-1:0]         cnt_prev, cnt_new;
  logic [CW1-1:0]        cnt_sum;
  logic [2:0]            code_prev, beat_code, final_code;
  logic [KCW-1:0]        kcnt;
  logic [KW-1:0]         keep_inc;
  logic                  keep_err, pat_err, port_err, seq_err, ch_ok;

  assign xfer      = s_axis_tvalid && s_axis_tready;
  assign first     = (state == S_FIRST);
  assign frame_end = xfer && s_axis_tlast;
  assign cur_ch    = first ? s_axis_tuser_in_port       : ch_q;
  assign cur_len   = first ? s_axis_tuser_packet_length : len_q;
  assign cur_base  = first ? s_axis_tdata[7:0]          : base_q;
  assign cur_off   = first ? 8'd0                       : off_q;
  assign cnt_prev  = first ? '0                         : cnt_q;
  assign code_prev = first ? ERR_NONE                   : code_q;
  assign ch_ok     = ({1'b0, cur_ch} < PW1'(NUM_CH));
  assign keep_inc  = s_axis_tkeep + KW'(1);

  always_comb begin
    kcnt    = '0;
    pat_err = 1'b0;
    for (int i = 0; i < KW; i++) begin
      kcnt = kcnt + KCW'(s_axis_tkeep[i]);
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != (cur_base + cur_off + 8'(i))))
        pat_err = 1'b1;
    end
  end

  // A contiguous low-aligned mask has no bit in common with itself plus one.
  assign keep_err = s_axis_tlast ? ((s_axis_tkeep & keep_inc) != '0) : (s_axis_tkeep != '1);
  assign port_err = !first && (s_axis_tuser_in_port != ch_q);
  assign cnt_sum  = {1'b0, cnt_prev} + CW1'(kcnt);
  assign cnt_new  = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
  assign seq_err  = ch_ok && seed_valid[cur_ch] && (cur_base != exp_base[cur_ch]);

  always_comb begin
    if (code_prev != ERR_NONE) beat_code = code_prev;
    else if (keep_err)         beat_code = ERR_KEEP;
    else if (pat_err)          beat_code = ERR_PATTERN;
    else if (port_err)         beat_code = ERR_PORT;
    else                       beat_code = ERR_NONE;

    if (!ch_ok)                          final_code = ERR_BADCH;
    else if (beat_code != ERR_NONE)      final_code = beat_code;
    else if (cnt_new != {1'b0, cur_len}) final_code = ERR_LEN;
    else if (seq_err)                    final_code = ERR_SEQ;
    else                                 final_code = ERR_NONE;
  end

  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state  <= S_FIRST;
      ch_q   <= '0;
      len_q  <= '0;
      base_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      code_q <= ERR_NONE;
    end else if (xfer) begin
      state  <= s_axis_tlast ? S_FIRST : S_BODY;
      ch_q   <= cur_ch;
      len_q  <= cur_len;
      base_q <= cur_base;
      off_q  <= cur_off + 8'(kcnt);
      cnt_q  <= cnt_new;
      code_q <= beat_code;
    end
  end

  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_ch    <= '0;
    end else begin
      err_valid <= frame_end && (final_code != ERR_NONE);
      err_code  <= frame_end ? final_code : ERR_NONE;
      err_ch    <= (frame_end && final_code != ERR_NONE) ? cur_ch : '0;
    end
  end

  // Clear takes priority over a coinciding frame result, including the sequence seed.
  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      seed_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        good[c]     <= '0;
        bad[c]      <= '0;
        exp_base[c] <= '0;
      end
    end else if (stat_clear) begin
      seed_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        good[c] <= '0;
        bad[c]  <= '0;
      end
    end else if (frame_end && ch_ok) begin
      seed_valid[cur_ch] <= 1'b1;
      exp_base[cur_ch]   <= cur_base + 8'd1;
      if (final_code == ERR_NONE) begin
        if (good[cur_ch] != '1) good[cur_ch] <= good[cur_ch] + 1'b1;
      end else begin
        if (bad[cur_ch] != '1) bad[cur_ch] <= bad[cur_ch] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if ({1'b0, stat_ch_sel} < PW1'(NUM_CH)) begin
      stat_good <= good[stat_ch_sel];
      stat_bad  <= bad[stat_ch_sel];
    end else begin
      stat_good <= '0;
      stat_bad  <= '0;
    end
  end

`ifdef FRAME_CHECK_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:2];

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (axi_resetn),
    .en    (1'b1),
    .state (lfsr_q)
  );

  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) s_axis_tready <= 1'b0;
    else             s_axis_tready <= (lfsr_q[1:0] != 2'b00);
  end
`else
  always_ff @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) s_axis_tready <= 1'b0;
    else             s_axis_tready <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_frame_check_mc.sv
// Scoreboard bench for frame_check_mc: directed frames push expected error events,
// a negedge monitor pops and compares them; counters are read back via stat_ch_sel.
module tb_frame_check_mc;

  localparam int DW = 256;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          axi_resetn;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [13:0]   plen;
  logic [2:0]    in_port;
  logic          tvalid, tready, tlast;
  logic          stat_clear;
  logic [2:0]    stat_ch_sel;
  logic [31:0]   stat_good, stat_bad;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [2:0]    err_ch;

  frame_check_mc dut (
    .clk                        (clk),
    .axi_resetn                 (axi_resetn),
    .s_axis_tdata               (tdata),
    .s_axis_tkeep               (tkeep),
    .s_axis_tuser_packet_length (plen),
    .s_axis_tuser_in_port       (in_port),
    .s_axis_tuser_out_port      (8'd0),
    .s_axis_tuser_in_vport      (3'd0),
    .s_axis_tuser_out_vport     (8'd0),
    .s_axis_tvalid              (tvalid),
    .s_axis_tready              (tready),
    .s_axis_tlast               (tlast),
    .stat_clear                 (stat_clear),
    .stat_ch_sel                (stat_ch_sel),
    .stat_good                  (stat_good),
    .stat_bad                   (stat_bad),
    .err_valid                  (err_valid),
    .err_code                   (err_code),
    .err_ch                     (err_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic [2:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic meas     = 1'b0;
  int   vcyc     = 0;
  int   rcyc     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (meas && tvalid) begin
        vcyc++;
        if (tready) rcyc++;
      end
      if (axi_resetn && err_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err actual=code%0d/ch%0d required=none", err_code, err_ch);
        end else begin
          e = exp_q.pop_front();
          chk("err_code", 64'(err_code), 64'(e.code));
          chk("err_ch", 64'(err_ch), 64'(e.ch));
        end
      end
    end
  end

  // nbytes sent, len_field in tuser; corrupt<0 means clean; keep0!=0 overrides beat 0;
  // port1 is in_port for beats after the first; stop>0 aborts after that many beats.
  task automatic send_frame(input int ch, input int nbytes, input int len_field,
                            input logic [7:0] base, input int corrupt,
                            input logic [KW-1:0] keep0, input int port1,
                            input int stop, input logic [2:0] exp_code);
    int nb;
    int guard;
    exp_t e;
    nb = (nbytes + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      if (stop != 0 && b == stop) begin
        tvalid = 1'b0;
        return;
      end
      for (int i = 0; i < KW; i++) begin
        int off;
        off = b * KW + i;
        tdata[8*i +: 8] = base + 8'(off);
        if (off == corrupt) tdata[8*i +: 8] = tdata[8*i +: 8] ^ 8'hFF;
        tkeep[i] = (off < nbytes);
      end
      if (b == 0 && keep0 != '0) tkeep = keep0;
      in_port = (b == 0) ? 3'(ch) : 3'(port1);
      plen    = 14'(len_field);
      tlast   = (b == nb - 1);
      tvalid  = 1'b1;
      if (tlast && stop == 0 && exp_code != 3'd0) begin
        e.code = exp_code;
        e.ch   = 3'(ch);
        exp_q.push_back(e);
      end
      guard = 0;
      while (!tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!tready) begin
        chk("tready_timeout", 64'(tready), 64'd1);
        tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("err_pulse_latency", 64'(err_valid), 64'(exp_code != 3'd0));
  endtask

  task automatic stat_chk(input int ch, input int g, input int b);
    stat_ch_sel = 3'(ch);
    @(negedge clk);
    chk($sformatf("good[%0d]", ch), 64'(stat_good), 64'(g));
    chk($sformatf("bad[%0d]", ch), 64'(stat_bad), 64'(b));
  endtask

  initial begin
    axi_resetn  = 1'b0;
    tdata       = '0;
    tkeep       = '0;
    plen        = '0;
    in_port     = '0;
    tvalid      = 1'b0;
    tlast       = 1'b0;
    stat_clear  = 1'b0;
    stat_ch_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_stat_good", 64'(stat_good), 64'd0);
    axi_resetn = 1'b1;
    @(negedge clk);
`ifndef FRAME_CHECK_THROTTLE_EN
    chk("tready_after_reset", 64'(tready), 64'd1);
`endif

    // Clean frames on ch 0, including a 14-byte tail and a short tail.
    send_frame(0, 64,   64,   8'h10, -1, '0, 0, 0, 3'd0);
    send_frame(0, 65,   65,   8'h11, -1, '0, 0, 0, 3'd0);
    send_frame(0, 1518, 1518, 8'h12, -1, '0, 0, 0, 3'd0);
    stat_chk(0, 3, 0);

    send_frame(2, 96, 96, 8'h30, 40, '0, 2, 0, 3'd2);
    stat_chk(2, 0, 1);

    send_frame(6, 96, 100, 8'h50, -1, '0, 6, 0, 3'd4);
    send_frame(6, 96, 96,  8'h51, -1, 32'hFFFF_FFF0, 6, 0, 3'd1);
    stat_chk(6, 0, 2);

    send_frame(7, 64, 64, 8'h70, -1, '0, 6, 0, 3'd3);
    stat_chk(7, 0, 1);

    send_frame(5, 64, 64, 8'h20, -1, '0, 5, 0, 3'd0);
    send_frame(5, 64, 64, 8'h21, -1, '0, 5, 0, 3'd0);
    send_frame(5, 64, 64, 8'h23, -1, '0, 5, 0, 3'd5);
    stat_chk(5, 2, 1);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    stat_chk(5, 0, 0);
    stat_chk(0, 0, 0);
    send_frame(5, 64, 64, 8'h40, -1, '0, 5, 0, 3'd0);
    stat_chk(5, 1, 0);

    // Abort a frame on ch 1 with reset; stat_ch_sel still points at ch 5.
    stat_ch_sel = 3'd5;
    send_frame(1, 96, 96, 8'h60, -1, '0, 1, 2, 3'd0);
    axi_resetn = 1'b0;
    #1;
    chk("midrst_tready", 64'(tready), 64'd0);
    chk("midrst_err_valid", 64'(err_valid), 64'd0);
    chk("midrst_stat_good", 64'(stat_good), 64'd0);
    @(negedge clk);
    axi_resetn = 1'b1;
    @(negedge clk);
    send_frame(1, 96, 96, 8'h61, -1, '0, 1, 0, 3'd0);
    stat_chk(1, 1, 0);
    stat_chk(5, 0, 0);

    meas = 1'b1;
    for (int n = 0; n < 1000; n++)
      send_frame(3, 64, 64, 8'(n), -1, '0, 3, 0, 3'd0);
    meas = 1'b0;
    stat_chk(3, 1000, 0);
`ifdef FRAME_CHECK_THROTTLE_EN
    chk("duty_ge_70", 64'(rcyc * 100 >= vcyc * 70), 64'd1);
    chk("duty_le_80", 64'(rcyc * 100 <= vcyc * 80), 64'd1);
`else
    chk("duty_full", 64'(rcyc), 64'(vcyc));
`endif

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
